// File: rtl/ether_rx_ctrl.sv
// ether_rx_ctrl: packs N-bit words from the preamble stripper into bytes, frames them, checks length.
// Optional destination-MAC filter enabled by defining ETHER_RX_MAC_FILTER_EN. Rev 1.0
`default_nettype none

module ether_rx_ctrl #(
  parameter int          N         = 2,
  parameter logic [47:0] MAC       = 48'h02_12_34_56_78_9A,
  parameter int          MIN_BYTES = 60,
  parameter int          MAX_BYTES = 1518
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [7:0]   axiod,
  output logic         done,
  output logic [1:0]   err,
  output logic [10:0]  len,
  output logic         abort
);

  localparam int          WPB       = 8 / N;
  localparam logic [2:0]  LAST_W    = 3'(WPB - 1);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_BYTES);
  localparam logic [10:0] GIANT_LEN = 11'(MAX_BYTES + 1);
  localparam logic [10:0] MIN_LEN   = 11'(MIN_BYTES);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_IDLE = 3'd1,
    S_DST  = 3'd2,
    S_BODY = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_w;
  logic [7:0]  r_byte;
  logic [10:0] r_cnt;
  logic        r_giant;
  logic        r_aborted;
  logic [7:0]  w_byte;
  logic        w_last;
  logic        w_dst_ok;

  // Current byte with the incoming word dropped into its slot (LSB-first).
  always_comb begin
    w_byte = r_byte;
    for (int i = 0; i < WPB; i++) begin
      if (r_w == 3'(i)) w_byte[i*N +: N] = axiid;
    end
  end

  assign w_last = (r_w == LAST_W);

`ifdef ETHER_RX_MAC_FILTER_EN
  logic [39:0] r_dst;
  logic [47:0] w_dst_full;
  logic        r_abort;

  assign w_dst_full = {r_dst, w_byte};
  assign w_dst_ok   = (w_dst_full == MAC) || (w_dst_full == {48{1'b1}});
  assign abort      = r_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (r_state == S_DST && axiiv && w_last) begin
        r_dst <= {r_dst[31:0], w_byte};
        if (r_cnt == 11'd5 && !w_dst_ok) r_abort <= 1'b1;
      end
    end
  end
`else
  logic w_unused_mac;
  assign w_unused_mac = ^MAC;
  assign w_dst_ok     = 1'b1;
  assign abort        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT;
      r_w       <= '0;
      r_byte    <= '0;
      r_cnt     <= '0;
      r_giant   <= 1'b0;
      r_aborted <= 1'b0;
      axiov     <= 1'b0;
      axiod     <= '0;
      done      <= 1'b0;
      err       <= '0;
      len       <= '0;
    end else begin
      axiov <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_WAIT: if (!axiiv) r_state <= S_IDLE;
        S_IDLE: begin
          if (axiiv) begin
            r_byte  <= w_byte;
            r_w     <= 3'd1;
            r_state <= S_DST;
          end
        end
        S_DST, S_BODY, S_DROP: begin
          if (!axiiv) begin
            // Frame end: report unless the filter already discarded it.
            r_state <= S_IDLE;
            if (!r_aborted) begin
              done <= 1'b1;
              len  <= r_cnt;
              if (r_giant)             err <= 2'b10;
              else if (r_w != 3'd0)    err <= 2'b11;
              else if (r_cnt < MIN_LEN) err <= 2'b01;
              else                     err <= 2'b00;
            end
            r_w       <= '0;
            r_cnt     <= '0;
            r_giant   <= 1'b0;
            r_aborted <= 1'b0;
          end else begin
            r_byte <= w_byte;
            r_w    <= w_last ? 3'd0 : r_w + 3'd1;
            if (w_last) begin
              if (r_state == S_DST) begin
                r_cnt <= r_cnt + 11'd1;
                if (r_cnt == 11'd5 && !w_dst_ok) begin
                  r_aborted <= 1'b1;
                  r_state   <= S_DROP;
                end else begin
                  axiov <= 1'b1;
                  axiod <= w_byte;
                  if (r_cnt == 11'd5) r_state <= S_BODY;
                end
              end else if (r_state == S_BODY) begin
                if (r_cnt == MAX_LEN) begin
                  r_cnt   <= GIANT_LEN;
                  r_giant <= 1'b1;
                  r_state <= S_DROP;
                end else begin
                  r_cnt <= r_cnt + 11'd1;
                  axiov <= 1'b1;
                  axiod <= w_byte;
                end
              end
            end
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ether_rx_ctrl.sv
// tb_ether_rx_ctrl: directed and random frames (N=4) checked against a frame-level reference model.
`default_nettype none

module tb_ether_rx_ctrl;
  localparam int          N   = 4;
  localparam logic [47:0] MAC = 48'h02_12_34_56_78_9A;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam int          MIN = 60;
  localparam int          MAX = 1518;
`ifdef ETHER_RX_MAC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         axiiv;
  logic [N-1:0] axiid;
  logic         axiov;
  logic [7:0]   axiod;
  logic         done;
  logic [1:0]   err;
  logic [10:0]  len;
  logic         abort;

  ether_rx_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .done(done), .err(err), .len(len), .abort(abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame[$];
  logic [7:0]  exp_b[$];
  logic [12:0] exp_d[$];
  int          exp_abort;
  logic [7:0]  got_b[$];
  logic [12:0] got_d[$];
  int          got_abort = 0;
  int          overlap = 0;
  int          gb0, gd0, ga0, go0;

  // Passive observer of the DUT output stream.
  always @(negedge clk) begin
    if (axiov) got_b.push_back(axiod);
    if (done) got_d.push_back({err, len});
    if (abort) got_abort++;
    if (axiov && done) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d);
    @(posedge clk);
    #1;
    axiiv = v;
    axiid = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0);
  endtask

  task automatic make(input logic [47:0] dst, input int n, input bit rnd);
    logic [7:0] b;
    frame.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 6) b = dst[47-8*i -: 8];
      else if (rnd) b = 8'($urandom);
      else b = 8'(i);
      frame.push_back(b);
    end
  endtask

  task automatic send(input int extra);
    foreach (frame[i]) begin
      drive(1'b1, frame[i][3:0]);
      drive(1'b1, frame[i][7:4]);
    end
    repeat (extra) drive(1'b1, 4'($urandom));
  endtask

  // Frame-level outcome from the length, destination and trailing-nibble rules.
  task automatic model(input int extra);
    int n, fw, l, e;
    logic [47:0] d;
    n = frame.size();
    d = '0;
    if (n >= 6) d = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
    if (FILT && n >= 6 && d != MAC && d != BC) begin
      for (int i = 0; i < 5; i++) exp_b.push_back(frame[i]);
      exp_abort++;
      return;
    end
    fw = (n > MAX) ? MAX : n;
    for (int i = 0; i < fw; i++) exp_b.push_back(frame[i]);
    l = (n > MAX) ? MAX + 1 : n;
    e = (n > MAX) ? 2 : (extra != 0) ? 3 : (n < MIN) ? 1 : 0;
    exp_d.push_back({2'(e), 11'(l)});
  endtask

  task automatic begin_group();
    exp_b.delete();
    exp_d.delete();
    exp_abort = 0;
    gb0 = got_b.size();
    gd0 = got_d.size();
    ga0 = got_abort;
    go0 = overlap;
  endtask

  task automatic end_group(input string name);
    int mism, nb, nd;
    idle(6);
    nb = got_b.size() - gb0;
    nd = got_d.size() - gd0;
    chk({name, ".nbytes"}, nb, exp_b.size());
    mism = 0;
    for (int i = 0; i < nb && i < exp_b.size(); i++)
      if (got_b[gb0+i] !== exp_b[i]) mism++;
    chk({name, ".bytes"}, mism, 0);
    chk({name, ".ndone"}, nd, exp_d.size());
    for (int i = 0; i < nd && i < exp_d.size(); i++)
      chk({name, ".err_len"}, got_d[gd0+i], exp_d[i]);
    chk({name, ".abort"}, got_abort - ga0, exp_abort);
    chk({name, ".done_vs_axiov"}, overlap - go0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] dst;
    int n, extra;
    rst = 1'b1;
    axiiv = 1'b0;
    axiid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.axiov", axiov, 0);
    chk("reset.axiod", axiod, 0);
    chk("reset.done", done, 0);
    chk("reset.err", err, 0);
    chk("reset.len", len, 0);
    chk("reset.abort", abort, 0);
    idle(2);

    begin_group(); make(MAC, 64, 0); model(0); send(0); end_group("f64");
    begin_group(); make(MAC, 20, 0); model(0); send(0); end_group("runt20");
    begin_group(); make(MAC, 20, 1); model(1); send(1); end_group("partial");

    begin_group(); make(MAC, 1600, 0); model(0); send(0);
    chk("giant.early_done", got_d.size() - gd0, 0);
    end_group("giant");

    begin_group(); make(48'h02_00_00_00_00_01, 64, 1); model(0); send(0); end_group("mismatch");
    begin_group(); make(BC, 64, 1); model(0); send(0); end_group("bcast");

    // Reset mid-frame, then keep words flowing: nothing may be emitted until the line idles.
    make(MAC, 10, 0); send(0);
    @(posedge clk);
    #1;
    rst = 1'b1; axiiv = 1'b1; axiid = 4'($urandom);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst.axiov", axiov, 0);
    chk("midrst.axiod", axiod, 0);
    chk("midrst.done", done, 0);
    begin_group();
    repeat (30) drive(1'b1, 4'($urandom));
    end_group("rst_hold");
    begin_group(); make(MAC, 64, 1); model(0); send(0); end_group("after_rst");

    // Random frames back-to-back with 1..3 idle cycles between them.
    begin_group();
    for (int k = 0; k < 14; k++) begin
      case ($urandom % 3)
        0: dst = MAC;
        1: dst = BC;
        default: dst = {$urandom, 16'($urandom)};
      endcase
      n = $urandom_range(1, 90);
      extra = $urandom % 2;
      make(dst, n, 1);
      model(extra);
      send(extra);
      idle($urandom_range(1, 3));
    end
    end_group("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
